// File: rtl/tea_stream_ctl.sv
// APB-fronted stream controller: input FIFO -> four-phase req/ack core -> output FIFO.
// Define TEA_STREAM_IRQ_EN to add the irq output with CTRL[2] irq_en and CTRL[3] irq_sel.
module tea_stream_ctl #(
  parameter int DEPTH = 4
) (
  input  logic        pclk,
  input  logic        prstb,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        req,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic [31:0] rdata
`ifdef TEA_STREAM_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d, pslverr_q, pslverr_d, enable_q, enable_d;
  logic            discard_q, discard_d, ack_meta_q, ack_s_q;
  logic [31:0]     wdata_q, wdata_d, prdata_q, prdata_d;
  logic [AW-1:0]   in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [AW-1:0]   out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [31:0]     in_mem [DEPTH];
  logic [31:0]     out_mem [DEPTH];
  logic            in_full, in_empty, out_full, out_empty;
  logic            setup, access, apb_ok, sel_data, sel_status, sel_ctrl;
  logic            in_push, in_pop, out_push, out_pop, ctrl_wr, flush;
  logic [31:0]     status_word, ctrl_word;
  logic            unused_paddr;
`ifdef TEA_STREAM_IRQ_EN
  logic            irq_en_q, irq_en_d, irq_sel_q, irq_sel_d, irq_q, irq_d;
`endif

  assign unused_paddr = &{1'b0, paddr[31:4]};

  assign in_full   = (in_cnt_q == FULL_CNT);
  assign in_empty  = (in_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign out_empty = (out_cnt_q == '0);

  assign setup      = psel & ~penable;
  assign access     = psel & penable;
  assign sel_data   = (paddr[3:0] == 4'h0);
  assign sel_status = (paddr[3:0] == 4'h4);
  assign sel_ctrl   = (paddr[3:0] == 4'h8);

  assign status_word = {11'b0, 5'(out_cnt_q), 3'b0, 5'(in_cnt_q), 3'b0,
                        (state_q != S_IDLE), out_empty, out_full, in_empty, in_full};
`ifdef TEA_STREAM_IRQ_EN
  assign ctrl_word = {28'b0, irq_sel_q, irq_en_q, 1'b0, enable_q};
`else
  assign ctrl_word = {31'b0, enable_q};
`endif

  // The access decision reuses the error registered at setup, so the reported
  // pslverr and the FIFO side effect can never disagree.
  assign apb_ok  = access & ~pslverr_q;
  assign in_push = apb_ok & pwrite & sel_data;
  assign out_pop = apb_ok & ~pwrite & sel_data;
  assign ctrl_wr = apb_ok & pwrite & sel_ctrl;
  assign flush   = ctrl_wr & pwdata[1];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    req_d        = req_q;
    wdata_d      = wdata_q;
    discard_d    = discard_q;
    enable_d     = enable_q;
    prdata_d     = '0;
    pslverr_d    = 1'b0;
    in_pop       = 1'b0;
    out_push     = 1'b0;
    in_wr_ptr_d  = in_wr_ptr_q;
    in_rd_ptr_d  = in_rd_ptr_q;
    in_cnt_d     = in_cnt_q;
    out_wr_ptr_d = out_wr_ptr_q;
    out_rd_ptr_d = out_rd_ptr_q;
    out_cnt_d    = out_cnt_q;

    if (setup) begin
      if (sel_data) begin
        if (pwrite)         pslverr_d = in_full;
        else if (out_empty) pslverr_d = 1'b1;
        else                prdata_d  = out_mem[out_rd_ptr_q];
      end else if (sel_status) begin
        if (!pwrite) prdata_d = status_word;
      end else if (sel_ctrl) begin
        if (!pwrite) prdata_d = ctrl_word;
      end else begin
        pslverr_d = 1'b1;
      end
    end

    if (ctrl_wr) enable_d = pwdata[0];

    unique case (state_q)
      S_IDLE: if (enable_q && !in_empty && !out_full) begin
        state_d = S_REQ;
        in_pop  = 1'b1;
        wdata_d = in_mem[in_rd_ptr_q];
        req_d   = 1'b1;
      end
      S_REQ: if (ack_s_q) begin
        state_d  = S_CAPT;
        out_push = ~discard_q & ~flush;
        req_d    = 1'b0;
      end
      S_CAPT:  state_d = S_DRAIN;
      S_DRAIN: if (!ack_s_q) begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // A word launched or waiting for ack when flushed completes its handshake unrecorded.
    if (flush && state_d == S_REQ) discard_d = 1'b1;

    if (in_push)  in_wr_ptr_d  = in_wr_ptr_q + 1'b1;
    if (in_pop)   in_rd_ptr_d  = in_rd_ptr_q + 1'b1;
    if (out_push) out_wr_ptr_d = out_wr_ptr_q + 1'b1;
    if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + 1'b1;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
    if (flush) begin
      in_wr_ptr_d  = '0;
      in_rd_ptr_d  = '0;
      in_cnt_d     = '0;
      out_wr_ptr_d = '0;
      out_rd_ptr_d = '0;
      out_cnt_d    = '0;
    end
  end

`ifdef TEA_STREAM_IRQ_EN
  always_comb begin
    irq_en_d  = irq_en_q;
    irq_sel_d = irq_sel_q;
    if (ctrl_wr) begin
      irq_en_d  = pwdata[2];
      irq_sel_d = pwdata[3];
    end
    irq_d = irq_en_q & (irq_sel_q ? out_full : ~out_empty);
  end
  assign irq = irq_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      wdata_q      <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      enable_q     <= 1'b0;
      discard_q    <= 1'b0;
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      in_wr_ptr_q  <= '0;
      in_rd_ptr_q  <= '0;
      in_cnt_q     <= '0;
      out_wr_ptr_q <= '0;
      out_rd_ptr_q <= '0;
      out_cnt_q    <= '0;
`ifdef TEA_STREAM_IRQ_EN
      irq_en_q     <= 1'b0;
      irq_sel_q    <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      wdata_q      <= wdata_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      enable_q     <= enable_d;
      discard_q    <= discard_d;
      ack_meta_q   <= ack;
      ack_s_q      <= ack_meta_q;
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      in_cnt_q     <= in_cnt_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      out_cnt_q    <= out_cnt_d;
`ifdef TEA_STREAM_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_sel_q    <= irq_sel_d;
      irq_q        <= irq_d;
`endif
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge pclk) begin
    if (in_push)  in_mem[in_wr_ptr_q]   <= pwdata;
    if (out_push) out_mem[out_wr_ptr_q] <= rdata;
  end

  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;
  assign pready  = 1'b1;
  assign req     = req_q;
  assign wdata   = wdata_q;

endmodule
